// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file and its syscall unit.
package regfile_pkg;

    typedef enum logic [1:0] {
        SYS_IDLE = 2'd0,
        SYS_REQ  = 2'd1,
        SYS_WAIT = 2'd2,
        SYS_DONE = 2'd3
    } sys_state_e;

    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 2;
    localparam int REG_A0   = 10;
    localparam int REG_A7   = 17;

    function automatic int calc_aw(input int nregs);
        return $clog2(nregs);
    endfunction

endpackage

// File: rtl/regfile_ecall_fsm.sv
// Syscall request/response handshake: snapshots x17 and x10..x16, then writes the result back to x10.
module regfile_ecall_fsm
    import regfile_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ecall,
    input  logic              sys_req_ready,
    input  logic              sys_resp_valid,
    input  logic [XLEN-1:0]   sys_resp_data,
    input  logic [XLEN-1:0]   snap_num,
    input  logic [7*XLEN-1:0] snap_args,
    output logic              sys_req_valid,
    output logic              ecall_done,
    output logic [XLEN-1:0]   sys_num,
    output logic [7*XLEN-1:0] sys_args,
    output logic              wb_en,
    output logic [XLEN-1:0]   wb_data,
    output logic              busy_set,
    output logic [1:0]        state_o
);

    localparam logic [1:0] S_IDLE = 2'(SYS_IDLE);
    localparam logic [1:0] S_REQ  = 2'(SYS_REQ);
    localparam logic [1:0] S_WAIT = 2'(SYS_WAIT);
    localparam logic [1:0] S_DONE = 2'(SYS_DONE);

    logic [1:0]        state_q, state_d;
    logic              dropped_q, dropped_d;
    logic [XLEN-1:0]   num_q;
    logic [7*XLEN-1:0] args_q;

    // dropped_q remembers that ecall fell mid-transaction, so DONE lasts a single cycle.
    always_comb begin
        state_d   = state_q;
        dropped_d = dropped_q;
        busy_set  = 1'b0;
        wb_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                dropped_d = 1'b0;
                if (ecall) begin
                    state_d  = S_REQ;
                    busy_set = 1'b1;
                end
            end
            S_REQ: begin
                if (!ecall) dropped_d = 1'b1;
                if (sys_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!ecall) dropped_d = 1'b1;
                if (sys_resp_valid) begin
                    state_d = S_DONE;
                    wb_en   = 1'b1;
                end
            end
            S_DONE: begin
                if (!ecall || dropped_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            dropped_q <= 1'b0;
            num_q     <= '0;
            args_q    <= '0;
        end else begin
            state_q   <= state_d;
            dropped_q <= dropped_d;
            if (state_q == S_IDLE && ecall) begin
                num_q  <= snap_num;
                args_q <= snap_args;
            end
        end
    end

    // Decoded straight from the state register so reset drops the request asynchronously.
    assign sys_req_valid = (state_q == S_REQ);
    assign ecall_done    = (state_q == S_DONE);
    assign sys_num       = num_q;
    assign sys_args      = args_q;
    assign wb_data       = sys_resp_data;
    assign state_o       = state_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with busy scoreboard and syscall handshake.
// Build option: REGFILE_BYPASS_EN forwards same-cycle writes to every read port and to the syscall snapshot.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int SP_REG = REG_SP,
    localparam int AW    = calc_aw(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [XLEN-1:0]     stackptr,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic [NREGS-1:0]    busy,
    input  logic                ecall,
    output logic                ecall_done,
    output logic                sys_req_valid,
    input  logic                sys_req_ready,
    output logic [XLEN-1:0]     sys_num,
    output logic [7*XLEN-1:0]   sys_args,
    input  logic                sys_resp_valid,
    input  logic [XLEN-1:0]     sys_resp_data,
    output logic [1:0]          dbg_state
);

    logic [XLEN-1:0]   regs_q  [NREGS];
    logic [XLEN-1:0]   regs_d  [NREGS];
    logic [XLEN-1:0]   rd_view [NREGS];
    logic [NREGS-1:0]  wr_hit;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic              wb_en, busy_set;
    logic [XLEN-1:0]   wb_data;
    logic [XLEN-1:0]   snap_num;
    logic [7*XLEN-1:0] snap_args;

    // Later ports overwrite earlier ones; the syscall writeback is applied last so it wins.
    always_comb begin
        regs_d = regs_q;
        wr_hit = '0;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en[p]) begin
                regs_d[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
                wr_hit[wr_addr[p*AW +: AW]] = 1'b1;
            end
        end
        if (wb_en) begin
            regs_d[REG_A0] = wb_data;
            wr_hit[REG_A0] = 1'b1;
        end
        regs_d[REG_ZERO] = '0;
        wr_hit[REG_ZERO] = 1'b0;
    end

`ifdef REGFILE_BYPASS_EN
    assign rd_view = regs_d;
`else
    assign rd_view = regs_q;
`endif

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_data[i*XLEN +: XLEN] = rd_view[rd_addr[i*AW +: AW]];
        end
    end

    always_comb begin
        snap_num  = rd_view[REG_A7];
        snap_args = '0;
        for (int k = 0; k < 7; k++) begin
            snap_args[k*XLEN +: XLEN] = rd_view[REG_A0 + k];
        end
    end

    // Reserve is applied after the write clear so a new producer keeps the register busy.
    always_comb begin
        busy_d = busy_q & ~wr_hit;
        if (rsv_en && rsv_addr != '0) busy_d[rsv_addr] = 1'b1;
        if (busy_set) busy_d[REG_A0] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == SP_REG) ? stackptr : '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

    regfile_ecall_fsm #(.XLEN(XLEN)) u_ecall_fsm (
        .clk            (clk),
        .reset          (reset),
        .ecall          (ecall),
        .sys_req_ready  (sys_req_ready),
        .sys_resp_valid (sys_resp_valid),
        .sys_resp_data  (sys_resp_data),
        .snap_num       (snap_num),
        .snap_args      (snap_args),
        .sys_req_valid  (sys_req_valid),
        .ecall_done     (ecall_done),
        .sys_num        (sys_num),
        .sys_args       (sys_args),
        .wb_en          (wb_en),
        .wb_data        (wb_data),
        .busy_set       (busy_set),
        .state_o        (dbg_state)
    );

endmodule
